// File: rtl/wbf_pkg.sv
// Shared types and size helpers for the weight buffer and its memory.
package wbf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_FILL = 2'd2,
        ST_WORK = 2'd3
    } wbf_state_e;

    // Number of entries addressed by an addr_w-bit read address.
    function automatic int unsigned wbf_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Counter width: one extra bit so a full-depth count is representable.
    function automatic int unsigned wbf_cnt_w(input int unsigned addr_w);
        return addr_w + 32'd1;
    endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous memory; registered dout holds while en is low.
// Behavioural array, intended to be swapped for a foundry macro.
module sram_sp
    import wbf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned DEPTH = wbf_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents and dout have no reset, matching a typical SRAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/weight_buffer.sv
// Per-layer weight store: sequential fill from the global buffer, then random
// single-weight reads with one-cycle latency. WBF_RANGE_CHK_EN enables the
// out-of-range read check and the sticky WBFTOP_Err flag.
module weight_buffer
    import wbf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned WEI_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      TOPWBF_CfgVld,
    input  logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgNum,
    output logic                      WBFTOP_CfgRdy,
    output logic                      WBFTOP_Err,
    input  logic                      GLBWBF_DatVld,
    input  logic [DATA_WIDTH-1:0]     GLBWBF_Dat,
    output logic                      WBFGLB_DatRdy,
    input  logic                      WCAWBF_AdrVld,
    input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
    output logic                      WBFWCA_AdrRdy,
    output logic                      WBFWCA_DatVld,
    output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
    input  logic                      WCAWBF_DatRdy
);

    localparam int unsigned DEPTH = wbf_depth(WEI_ADDR_WIDTH);
    localparam int unsigned CNT_W = wbf_cnt_w(WEI_ADDR_WIDTH);

    wbf_state_e state_q, state_d;

    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] cfg_num_clamped;
    logic             dat_vld_q, dat_vld_d;
    logic             dat_mask_q, dat_mask_d;
    logic             fill_hs;
    logic             rd_en;
    logic             adr_oor;
    logic             cfg_start;
    logic             last_beat;

    logic                      mem_en;
    logic                      mem_we;
    logic [WEI_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_dout;

    assign cfg_num_clamped = (TOPWBF_CfgNum > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : TOPWBF_CfgNum;
    assign cfg_start       = (state_q == ST_IDLE) && TOPWBF_CfgVld;

    assign WBFTOP_CfgRdy = (state_q == ST_IDLE);
    assign WBFGLB_DatRdy = (state_q == ST_FILL);
    assign WBFWCA_AdrRdy = (state_q == ST_WORK) && (!dat_vld_q || WCAWBF_DatRdy);
    assign WBFWCA_DatVld = dat_vld_q;

    assign fill_hs   = GLBWBF_DatVld && WBFGLB_DatRdy;
    assign rd_en     = WCAWBF_AdrVld && WBFWCA_AdrRdy;
    assign last_beat = fill_hs && (wr_cnt_q == (num_q - CNT_W'(1)));

    // Writes only happen in FILL and reads only in WORK, so one port suffices.
    assign mem_en   = fill_hs || rd_en;
    assign mem_we   = fill_hs;
    assign mem_addr = (state_q == ST_FILL) ? wr_cnt_q[WEI_ADDR_WIDTH-1:0] : WCAWBF_Adr;

    // Masked reads (reset, out-of-range) present zero without touching the array.
    assign WBFWCA_Dat = dat_mask_q ? '0 : mem_dout;

`ifdef WBF_RANGE_CHK_EN
    logic err_q;

    assign adr_oor    = rd_en && ({1'b0, WCAWBF_Adr} >= num_q);
    assign WBFTOP_Err = err_q;

    // Sticky until reset or the start of the next layer.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cfg_start) begin
            err_q <= 1'b0;
        end else if (adr_oor) begin
            err_q <= 1'b1;
        end
    end
`else
    assign adr_oor    = 1'b0;
    assign WBFTOP_Err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (TOPWBF_CfgVld) state_d = ST_CFG;
            ST_CFG:  state_d = (num_q != '0) ? ST_FILL : ST_WORK;
            ST_FILL: if (last_beat) state_d = ST_WORK;
            ST_WORK: if (TOPWBF_CfgVld) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Layer size, fill pointer and read-side valid/mask.
    always_comb begin
        num_d      = num_q;
        wr_cnt_d   = wr_cnt_q;
        dat_vld_d  = dat_vld_q;
        dat_mask_d = dat_mask_q;

        if (cfg_start) begin
            num_d = cfg_num_clamped;
        end

        if (state_q == ST_CFG) begin
            wr_cnt_d = '0;
        end else if (fill_hs) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end

        // Leaving WORK drops any pending beat.
        if ((state_q != ST_WORK) || TOPWBF_CfgVld) begin
            dat_vld_d = 1'b0;
        end else if (rd_en) begin
            dat_vld_d = 1'b1;
        end else if (WCAWBF_DatRdy) begin
            dat_vld_d = 1'b0;
        end

        if (rd_en) begin
            dat_mask_d = adr_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q      <= '0;
            wr_cnt_q   <= '0;
            dat_vld_q  <= 1'b0;
            dat_mask_q <= 1'b1;
        end else begin
            num_q      <= num_d;
            wr_cnt_q   <= wr_cnt_d;
            dat_vld_q  <= dat_vld_d;
            dat_mask_q <= dat_mask_d;
        end
    end

    sram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (WEI_ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (GLBWBF_Dat),
        .dout (mem_dout)
    );

endmodule

// File: tb/tb_weight_buffer.sv
// Self-checking bench for weight_buffer: directed tables, corner sequences
// and randomized reads against an array/scoreboard model of the buffer.
module tb_weight_buffer;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

`ifdef WBF_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_vld;
    logic [AW:0]   cfg_num;
    logic          cfg_rdy;
    logic          err;
    logic          glb_vld;
    logic [DW-1:0] glb_dat;
    logic          glb_rdy;
    logic          adr_vld;
    logic [AW-1:0] adr;
    logic          adr_rdy;
    logic          dat_vld;
    logic [DW-1:0] dat;
    logic          dat_rdy;

    weight_buffer #(
        .DATA_WIDTH     (DW),
        .WEI_ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .TOPWBF_CfgVld (cfg_vld),
        .TOPWBF_CfgNum (cfg_num),
        .WBFTOP_CfgRdy (cfg_rdy),
        .WBFTOP_Err    (err),
        .GLBWBF_DatVld (glb_vld),
        .GLBWBF_Dat    (glb_dat),
        .WBFGLB_DatRdy (glb_rdy),
        .WCAWBF_AdrVld (adr_vld),
        .WCAWBF_Adr    (adr),
        .WBFWCA_AdrRdy (adr_rdy),
        .WBFWCA_DatVld (dat_vld),
        .WBFWCA_Dat    (dat),
        .WCAWBF_DatRdy (dat_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: memory image, layer size and the read-side scoreboard.
    logic [DW-1:0] mem_m     [DEPTH];
    bit            known_arr [DEPTH];
    int            num_m;
    bit            vld_m;
    logic [DW-1:0] dat_m;
    bit            dat_known_m;
    bit            err_m;

    typedef struct {
        bit            av;
        int            a;
        bit            dr;
        bit            e_ardy;
        bit            e_vld;
        logic [DW-1:0] e_dat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cfg_rdy"}, 32'(cfg_rdy), 32'(1));
        chk({tag, "_err"},     32'(err),     32'(0));
        chk({tag, "_glb_rdy"}, 32'(glb_rdy), 32'(0));
        chk({tag, "_adr_rdy"}, 32'(adr_rdy), 32'(0));
        chk({tag, "_dat_vld"}, 32'(dat_vld), 32'(0));
        chk({tag, "_dat"},     32'(dat),     32'(0));
    endtask

    // Start a layer from IDLE and stream its beats; pat_base != 0 gives fixed data.
    task automatic fill_layer(input int cfg_n, input bit stall, input int pat_base);
        int n;
        int i;
        int cyc;
        bit v;
        n = (cfg_n > DEPTH) ? DEPTH : cfg_n;
        cfg_vld = 1'b1;
        cfg_num = (AW+1)'(cfg_n);
        #1;
        chk("cfg_rdy_idle", 32'(cfg_rdy), 32'(1));
        step();
        cfg_vld = 1'b0;
        num_m   = n;
        err_m   = 1'b0;
        chk("cfg_state", 32'({cfg_rdy, glb_rdy, adr_rdy}), 32'(3'b000));
        chk("cfg_err_clr", 32'(err), 32'(0));
        step();
        if (n == 0) begin
            chk("work_after_zero", 32'({glb_rdy, adr_rdy, cfg_rdy}), 32'(3'b010));
        end else begin
            i   = 0;
            cyc = 0;
            while (i < n && cyc < 4 * n + 8) begin
                v       = stall ? (cyc % 2 == 0) : 1'b1;
                glb_vld = v;
                glb_dat = (pat_base != 0) ? DW'(pat_base * (i + 1)) : DW'($urandom);
                #1;
                chk("fill_rdy", 32'(glb_rdy), 32'(1));
                if (v) begin
                    mem_m[i]     = glb_dat;
                    known_arr[i] = 1'b1;
                    i++;
                end
                step();
                cyc++;
            end
            glb_vld = 1'b0;
            if (i < n) chk("fill_timeout", 32'(i), 32'(n));
            chk("work_entry", 32'({glb_rdy, adr_rdy, cfg_rdy}), 32'(3'b010));
        end
    endtask

    task automatic end_layer();
        adr_vld = 1'b0;
        dat_rdy = 1'b0;
        cfg_vld = 1'b1;
        #1;
        step();
        cfg_vld = 1'b0;
        vld_m   = 1'b0;
        chk("idle_after_work", 32'({cfg_rdy, dat_vld, glb_rdy}), 32'(3'b100));
    endtask

    // One WORK cycle: compare against the scoreboard, then advance it.
    task automatic rd_cycle(input bit av, input int a, input bit dr);
        bit exp_ardy;
        adr_vld = av;
        adr     = AW'(a);
        dat_rdy = dr;
        #1;
        exp_ardy = !vld_m || dr;
        chk("rd_adr_rdy", 32'(adr_rdy), 32'(exp_ardy));
        chk("rd_dat_vld", 32'(dat_vld), 32'(vld_m));
        if (vld_m && dat_known_m) chk("rd_dat", 32'(dat), 32'(dat_m));
        chk("rd_err", 32'(err), 32'(err_m));
        if (av && exp_ardy) begin
            vld_m = 1'b1;
            if (RANGE_CHK && a >= num_m) begin
                dat_m       = '0;
                dat_known_m = 1'b1;
                err_m       = 1'b1;
            end else begin
                dat_m       = mem_m[a];
                dat_known_m = known_arr[a];
            end
        end else if (dr) begin
            vld_m = 1'b0;
        end
        step();
    endtask

    task automatic rand_reads(input int n, input int a_max);
        for (int k = 0; k < n; k++) begin
            rd_cycle(1'($urandom), $urandom_range(a_max, 0), ($urandom % 4) != 0);
        end
        rd_cycle(1'b0, 0, 1'b1);
        rd_cycle(1'b0, 0, 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        cfg_vld = 1'b0;
        cfg_num = '0;
        glb_vld = 1'b0;
        glb_dat = '0;
        adr_vld = 1'b0;
        adr     = '0;
        dat_rdy = 1'b0;
        vld_m   = 1'b0;
        err_m   = 1'b0;
        num_m   = 0;
        dat_m   = '0;
        dat_known_m = 1'b0;
        for (int k = 0; k < DEPTH; k++) known_arr[k] = 1'b0;

        // Back-to-back reads of 3 then 0, then addr 1 held under back-pressure.
        vecs[0] = '{1'b1, 3, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 0, 1'b1, 1'b1, 1'b1, 8'h44};
        vecs[2] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 8'h11};
        vecs[3] = '{1'b1, 1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[5] = '{1'b1, 2, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[6] = '{1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[7] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 8'h22};
        vecs[8] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 8'h00};

        step();
        step();
        rst = 1'b0;
        check_reset("reset");

        fill_layer(4, 1'b0, 'h11);
        for (int r = 0; r < 9; r++) begin
            adr_vld = vecs[r].av;
            adr     = AW'(vecs[r].a);
            dat_rdy = vecs[r].dr;
            #1;
            chk($sformatf("tbl%0d_adr_rdy", r), 32'(adr_rdy), 32'(vecs[r].e_ardy));
            chk($sformatf("tbl%0d_dat_vld", r), 32'(dat_vld), 32'(vecs[r].e_vld));
            if (vecs[r].e_vld) chk($sformatf("tbl%0d_dat", r), 32'(dat), 32'(vecs[r].e_dat));
            step();
        end
        vld_m = 1'b0;

        // Out-of-range read: zero data and a sticky error when checking is built in.
        rd_cycle(1'b1, 9, 1'b1);
        rd_cycle(1'b0, 0, 1'b1);
        rd_cycle(1'b0, 0, 1'b1);
        rd_cycle(1'b0, 0, 1'b1);
        end_layer();

        // Stalled fill of two beats; entries 2 and 3 keep the previous layer.
        fill_layer(2, 1'b1, 0);
        rand_reads(30, 3);
        end_layer();

        fill_layer(0, 1'b0, 0);
        rand_reads(10, 3);
        end_layer();

        // Oversized config clamps to the full depth.
        fill_layer(300, 1'b0, 0);
        rand_reads(400, DEPTH - 1);

        // Reset with a read beat pending.
        rd_cycle(1'b1, 5, 1'b0);
        adr_vld = 1'b0;
        rst     = 1'b1;
        step();
        rst   = 1'b0;
        vld_m = 1'b0;
        err_m = 1'b0;
        check_reset("rst_work");

        // Reset after two of four fill beats, then a clean layer.
        cfg_vld = 1'b1;
        cfg_num = (AW+1)'(4);
        step();
        cfg_vld = 1'b0;
        step();
        for (int b = 0; b < 2; b++) begin
            glb_vld      = 1'b1;
            glb_dat      = DW'($urandom);
            mem_m[b]     = glb_dat;
            known_arr[b] = 1'b1;
            step();
        end
        glb_vld = 1'b0;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        check_reset("rst_fill");

        fill_layer(4, 1'b0, 0);
        rand_reads(30, 3);
        rand_reads(20, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
